// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one shared req/ack memory port.
// Illegal encodings or HALT_WORD park the core in HALT until reset.
module mc_cpu #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        halted,
  output logic [31:0] debug_wb_pc,
  output logic        debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_addr,
  output logic [31:0] debug_wb_rf_wdata
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa, dest;
  logic [31:0] imm_s, imm_z, alu_res, wb_data;
  logic        is_rtype, is_lw, is_sw, is_branch, is_jump, br_taken, wb_wen;

  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign sa        = ir[10:6];
  assign funct     = ir[5:0];
  assign imm_s     = {{16{ir[15]}}, ir[15:0]};
  assign imm_z     = {16'h0000, ir[15:0]};
  assign is_rtype  = (opcode == 6'h00);
  assign is_lw     = (opcode == 6'h23);
  assign is_sw     = (opcode == 6'h2B);
  assign is_branch = (opcode == 6'h04) || (opcode == 6'h05);
  assign is_jump   = (opcode == 6'h02);
  assign br_taken  = (opcode == 6'h04) ? (a == b) : (a != b);
  assign dest      = is_rtype ? rd : rt;
  assign wb_data   = is_lw ? mdr : alu_out;
  assign wb_wen    = (state == S_WB) && (dest != 5'd0);

  // Legality is judged on the word arriving from memory so FETCH can branch straight to HALT.
  function automatic logic legal(input logic [31:0] w);
    logic ok;
    ok = 1'b0;
    if (w != HALT_WORD) begin
      case (w[31:26])
        6'h00: begin
          case (w[5:0])
            6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02: ok = 1'b1;
            default: ok = 1'b0;
          endcase
        end
        6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  always_comb begin
    alu_res = a + imm_s;
    if (is_rtype) begin
      case (funct)
        6'h21:   alu_res = a + b;
        6'h23:   alu_res = a - b;
        6'h24:   alu_res = a & b;
        6'h25:   alu_res = a | b;
        6'h26:   alu_res = a ^ b;
        6'h2A:   alu_res = {31'd0, $signed(a) < $signed(b)};
        6'h00:   alu_res = b << sa;
        6'h02:   alu_res = b >> sa;
        default: alu_res = a + b;
      endcase
    end else begin
      case (opcode)
        6'h0C:   alu_res = a & imm_z;
        6'h0D:   alu_res = a | imm_z;
        6'h0F:   alu_res = {ir[15:0], 16'h0000};
        default: alu_res = a + imm_s;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (mem_ack) state_nxt = legal(mem_rdata) ? S_DECODE : S_HALT;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw)          state_nxt = S_MEM;
        else if (is_branch || is_jump) state_nxt = S_FETCH;
        else                         state_nxt = S_WB;
      end
      S_MEM:    if (mem_ack) state_nxt = is_lw ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_HALT;
    endcase
  end

  // Bus outputs depend only on registered state, never on mem_ack.
  always_comb begin
    mem_req   = (state == S_FETCH) || (state == S_MEM);
    mem_we    = (state == S_MEM) && is_sw;
    mem_addr  = (state == S_MEM) ? {alu_out[31:2], 2'b00} : {pc[31:2], 2'b00};
    mem_wdata = ((state == S_MEM) && is_sw) ? b : 32'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (is_branch && br_taken) pc <= pc + {imm_s[29:0], 2'b00};
          if (is_jump)               pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        S_MEM: if (mem_ack && is_lw) mdr <= mem_rdata;
        S_WB:  if (dest != 5'd0) rf[dest] <= wb_data;
        default: ;
      endcase
    end
  end

  assign halted            = (state == S_HALT);
  assign debug_wb_rf_wen   = wb_wen;
  assign debug_wb_pc       = wb_wen ? pc - 32'd4 : 32'd0;
  assign debug_wb_rf_addr  = wb_wen ? dest : 5'd0;
  assign debug_wb_rf_wdata = wb_wen ? wb_data : 32'd0;
endmodule

// File: doc/mc_cpu.md
# mc_cpu

Multi-cycle MIPS-subset CPU core and successor to the single-cycle `cpu`. Instructions and data share one external memory port with a req/ack handshake, so memory can insert any number of wait states. The core sequences each instruction through a FETCH/DECODE/EXEC/MEM/WB state machine and adds a defined HALT state for illegal or halt encodings. Debug write-back ports keep the existing trace-compare format so the current reference-trace benches run unchanged.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that enters HALT.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low. Low clears all state immediately.
- `mem_req` output, 1 bit: memory request. Held high until acknowledged.
- `mem_we` output, 1 bit: 1 = write (sw), 0 = read (fetch or lw).
- `mem_addr` output, 32 bits: byte address, always word-aligned ([1:0]=0).
- `mem_wdata` output, 32 bits: store data.
- `mem_rdata` input, 32 bits: read data. Sampled on the cycle with `mem_ack`=1.
- `mem_ack` input, 1 bit: completes the request in the same cycle. May be combinational.
- `halted` output, 1 bit: high while in HALT.
- `debug_wb_pc` output, 32 bits: PC of the instruction currently writing back.
- `debug_wb_rf_wen` output, 1 bit: register-file write strobe.
- `debug_wb_rf_addr` output, 5 bits: destination register.
- `debug_wb_rf_wdata` output, 32 bits: value being written.

## Operation
- **Registers**
  - Internal: PC, IR, A, B, ALUOUT, MDR; 32x32 register file.
  - r0 reads as 0. Writes to r0 are discarded.
- **Supported instructions**
  - R-type by funct: addu 21h, subu 23h, and 24h, or 25h, xor 26h, slt 2Ah (signed), sll 00h, srl 02h. Shifts use `sa`=IR[10:6] applied to rt.
  - I-type by opcode: addiu 09h (sign-extended imm), andi 0Ch and ori 0Dh (zero-extended imm), lui 0Fh, lw 23h, sw 2Bh, beq 04h, bne 05h.
  - J-type: j 02h.
  - Arithmetic wraps modulo 2^32. No overflow traps.
- **States**
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. On ack: IR←mem_rdata, PC←PC+4. Next state is HALT if IR equals `HALT_WORD` or is an unsupported encoding, otherwise DECODE.
  - DECODE: A←rf[rs], B←rf[rt].
  - EXEC:
    - ALU ops: ALUOUT←result, then go to WB.
    - lw/sw: ALUOUT←A+sext(imm), then go to MEM.
    - beq/bne: if taken, PC←PC+(sext(imm)<<2), using the already-incremented PC. Then go to FETCH.
    - j: PC←{PC[31:28], IR[25:0], 2'b00}. Then go to FETCH.
  - MEM: `mem_req`=1, `mem_addr`={ALUOUT[31:2],2'b00}.
    - sw: `mem_we`=1, `mem_wdata`=B. On ack go to FETCH.
    - lw: on ack MDR←mem_rdata, then go to WB.
  - WB: rf[dest]←ALUOUT (or MDR for lw). dest = rd for R-type, rt for I-type. Next state FETCH.
  - HALT: terminal. Only reset exits. `mem_req`=0.
- **Debug ports**
  - `debug_wb_rf_wen`=1 only in the WB cycle, and only when dest≠0.
  - `debug_wb_pc`, `debug_wb_rf_addr` and `debug_wb_rf_wdata` are valid whenever wen=1.
  - When wen=0, the other debug outputs are don't-care but must not be X after reset.

## Timing
- **Reset values**
  - PC=`RESET_PC`; state FETCH, entered on the first edge after `reset` rises.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=`RESET_PC`, `mem_wdata`=0.
  - `halted`=0, all debug outputs 0.
  - Register file and internal registers all 0.
- **Bus outputs:** `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from registered state only, so they have no combinational path from `mem_ack`.
- **Cycle counts with zero wait states** (ack in the first request cycle):
  - R-type and ALU I-type: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j: 3.
  - Each wait cycle adds 1.
- **Handshake:** `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req`=1 and ack=0. `mem_req` drops on the cycle after ack.
- **Ack filtering:** `mem_ack` is ignored when `mem_req`=0.
- **Reset during an active request:** `mem_req` drops asynchronously. The memory side must tolerate the abandoned request. No register write occurs.
- **Branch and write-back targets:**
  - A branch to itself (imm=FFFFh) loops forever, re-fetching at the same PC.
  - PC wraps from FFFF_FFFC to 0000_0000.
  - lw with dest=r0 performs the read, but wen stays 0.

## Test plan
- **ALU sequence:** addiu r1,r0,5; addiu r2,r0,-3; addu r3,r1,r2; slt r4,r2,r1. Required: r3=2, r4=1, each WB trace entry correct, 4 cycles per instruction at 0 wait.
- **Load/store with wait states:** ack delayed 3 cycles. sw r1→0x100, then lw r5←0x100. Required: `mem_we`=1 only during the sw MEM phase; r5=5; addresses held stable during waits; lw takes 5+6 wait cycles.
- **Branches:** beq taken with imm=2 skips exactly 2 instructions. bne not-taken falls through. j 0x40 lands at PC=0x40. None of them produce a WB strobe.
- **Immediate ops and r0 writes:** lui r6,0x1234 then ori r6,r6,0xABCD gives 1234ABCD. andi with FFFFh zero-extends. addu r0,r1,r1 leaves r0=0 and wen=0.
- **Halt encodings:** `HALT_WORD` at 0x20 gives `halted`=1 and `mem_req`=0 permanently afterwards. An unsupported opcode 3Fh also halts.
- **Mid-transaction reset:** reset asserted low mid-fetch while ack is stalled. Required: outputs reach their reset values immediately. After release, the first fetch is at `RESET_PC`.
